// File: rtl/bgd_mul_pipe_fx.sv
// bgd_mul_pipe_fx
// Pipelined signed fixed-point multiplier for the BGD/sigmoid datapath.
//
// - The exact full-width product is formed in stage 2.
// - Stages 3..NUM_STAGE-1 are pure delay.
// - The last stage rounds (half up), shifts right by FRAC_SHIFT,
//   fits the value to P_WIDTH bits and flags overflow.
// - `ce` low freezes every pipeline register, including the valid chain.
// - clr_ovf acts on ovf_sticky regardless of ce.
//
// Build option:
//   BGD_MUL_SAT_EN  defined   -> out-of-range results saturate to the P_WIDTH limits.
//                   undefined -> out-of-range results wrap (two's complement).
//
// With default parameters and BGD_MUL_SAT_EN undefined, dout values and
// latency match the legacy 13x13->13 four-stage multiplier.
//
// Handshake: a sample is taken when in_valid=1 at a rising clk edge with
// ce=1. It is presented as out_valid=1 after NUM_STAGE enabled edges.
// There is no backpressure: the consumer must accept every out_valid=1
// cycle, and it stalls the whole pipe only through ce.
module bgd_mul_pipe_fx #(
    parameter int A_WIDTH    = 13,
    parameter int B_WIDTH    = 13,
    parameter int P_WIDTH    = 13,
    parameter int FRAC_SHIFT = 0,
    parameter int NUM_STAGE  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    input  logic               clr_ovf,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] dout,
    output logic               ovf,
    output logic               ovf_sticky
);

    // Full product width.
    localparam int PROD_W  = A_WIDTH + B_WIDTH;
    // Registers holding the product: stage 2 up to and including stage NUM_STAGE-1.
    localparam int DLY     = NUM_STAGE - 2;
    // Position of the rounding half-LSB (only meaningful when FRAC_SHIFT > 0).
    localparam int RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    // Rounding constant 2^(FRAC_SHIFT-1), or zero when there is no shift.
    localparam logic [PROD_W:0] RND_K =
        (FRAC_SHIFT > 0) ? ((PROD_W + 1)'(1) << RND_POS) : '0;
    // Width of the bits that must all equal the sign bit for r to fit.
    localparam int HI_W    = PROD_W - P_WIDTH + 2;

`ifdef BGD_MUL_SAT_EN
    localparam logic [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};
`endif

    // ------------------------------------------------------------------
    // Stage 1: operand and valid capture
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0] a_s1_q, a_s1_d;
    logic [B_WIDTH-1:0] b_s1_q, b_s1_d;
    logic               v_s1_q, v_s1_d;

    // Next-state for the input capture registers.
    always_comb begin
        a_s1_d = din0;
        b_s1_d = din1;
        v_s1_d = in_valid;
    end

    // Input capture registers, held while ce is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_s1_q <= '0;
            b_s1_q <= '0;
            v_s1_q <= 1'b0;
        end else if (ce) begin
            a_s1_q <= a_s1_d;
            b_s1_q <= b_s1_d;
            v_s1_q <= v_s1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 (product) and stages 3..NUM_STAGE-1 (delay)
    // Element 0 is the freshly formed product; the last element feeds
    // the output stage.
    // ------------------------------------------------------------------
    logic [DLY-1:0][PROD_W-1:0] prod_q, prod_d;
    logic [DLY-1:0]             pv_q, pv_d;

    // Exact signed product into element 0; the remaining elements shift along.
    always_comb begin
        prod_d[0] = PROD_W'($signed(a_s1_q)) * PROD_W'($signed(b_s1_q));
        pv_d[0]   = v_s1_q;
        for (int i = 1; i < DLY; i++) begin
            prod_d[i] = prod_q[i-1];
            pv_d[i]   = pv_q[i-1];
        end
    end

    // Product and delay registers, held while ce is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            pv_q   <= '0;
        end else if (ce) begin
            prod_q <= prod_d;
            pv_q   <= pv_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage: round, shift, fit, overflow
    // ------------------------------------------------------------------
    logic signed [PROD_W:0] ext_prod;
    logic signed [PROD_W:0] rnd_sum;
    logic signed [PROD_W:0] res_r;
    logic [HI_W-1:0]        res_hi;
    logic                   res_fits;
    logic [P_WIDTH-1:0]     dout_q, dout_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;

    // Rounding is done one bit wider than the product so the half-LSB add cannot wrap.
    always_comb begin
        ext_prod = {prod_q[DLY-1][PROD_W-1], prod_q[DLY-1]};
        rnd_sum  = ext_prod + $signed(RND_K);
        res_r    = rnd_sum >>> FRAC_SHIFT;
        // r fits when every bit from P_WIDTH-1 upward equals the sign bit.
        res_hi   = res_r[PROD_W:P_WIDTH-1];
        res_fits = (&res_hi) | ~(|res_hi);

        out_valid_d = pv_q[DLY-1];
        // Overflow is only reported for slots that carry a real sample.
        ovf_d       = pv_q[DLY-1] & ~res_fits;
`ifdef BGD_MUL_SAT_EN
        if (res_fits) begin
            dout_d = res_r[P_WIDTH-1:0];
        end else if (res_r[PROD_W]) begin
            dout_d = P_MIN;
        end else begin
            dout_d = P_MAX;
        end
`else
        dout_d = res_r[P_WIDTH-1:0];
`endif
    end

    // Output registers, held while ce is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow
    // ------------------------------------------------------------------
    logic ovf_sticky_q, ovf_sticky_d;

    // Set when an overflowing result is consumed on an enabled edge.
    // Set beats a simultaneous clear; a clear alone works even while ce is low.
    always_comb begin
        ovf_sticky_d = (ce & out_valid_q & ovf_q) | (ovf_sticky_q & ~clr_ovf);
    end

    // Sticky overflow register; not gated by ce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign dout       = dout_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_bgd_mul_pipe_fx.sv
// Bench for bgd_mul_pipe_fx. Two instances share their inputs:
//   dut_a: default parameters (13x13->13, no shift, 4 stages)
//   dut_b: FRAC_SHIFT=8, P_WIDTH=16
// Expected results come from a hand-written vector table and from an
// integer reference model; the model's latency is a queue of NUM_STAGE
// accepted slots.
module tb_bgd_mul_pipe_fx;

    localparam int NS = 4;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [12:0] din0;
    logic [12:0] din1;
    logic        clr_ovf;

    logic        out_valid_a, ovf_a, sticky_a;
    logic [12:0] dout_a;
    logic        out_valid_b, ovf_b, sticky_b;
    logic [15:0] dout_b;

    always #5 clk = ~clk;

    bgd_mul_pipe_fx dut_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .clr_ovf(clr_ovf),
        .out_valid(out_valid_a), .dout(dout_a), .ovf(ovf_a), .ovf_sticky(sticky_a)
    );

    bgd_mul_pipe_fx #(
        .A_WIDTH(13), .B_WIDTH(13), .P_WIDTH(16), .FRAC_SHIFT(8), .NUM_STAGE(4)
    ) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .clr_ovf(clr_ovf),
        .out_valid(out_valid_b), .dout(dout_b), .ovf(ovf_b), .ovf_sticky(sticky_b)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        bit valid;
        int a;
        int b;
        int e0;   // expected dout of dut_a
        bit o0;   // expected ovf of dut_a
        int e8;   // expected dout of dut_b
        bit o8;   // expected ovf of dut_b
    } slot_t;

    typedef struct {
        int a;
        int b;
        int d0w;  // dut_a, wrapping build
        int d0s;  // dut_a, saturating build
        bit o0;
        int d8w;  // dut_b, wrapping build
        int d8s;  // dut_b, saturating build
        bit o8;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    slot_t hist[$];
    slot_t cur;
    bit    st_a;
    bit    st_b;
    vec_t  tab[14];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: exact product, round half up, shift, fit.
    function automatic void ref_mul(input int a, input int b, input int fs, input int pw,
                                    output int d, output bit o);
        longint p, r, span, hi, lo;
        p = longint'(a) * longint'(b);
        if (fs > 0) r = (p + (longint'(1) << (fs - 1))) >>> fs;
        else        r = p;
        span = longint'(1) << pw;
        hi   = span / 2 - 1;
        lo   = -(span / 2);
        o    = (r > hi) || (r < lo);
`ifdef BGD_MUL_SAT_EN
        if (r > hi)      d = int'(hi);
        else if (r < lo) d = int'(lo);
        else             d = int'(r);
`else
        r = r % span;
        if (r < 0)  r = r + span;
        if (r > hi) r = r - span;
        d = int'(r);
`endif
    endfunction

    function automatic slot_t mk_slot(input bit v, input int a, input int b);
        slot_t s;
        int    d;
        bit    o;
        s.valid = v;
        s.a = a;
        s.b = b;
        ref_mul(a, b, 0, 13, d, o);
        s.e0 = d;
        s.o0 = v & o;
        ref_mul(a, b, 8, 16, d, o);
        s.e8 = d;
        s.o8 = v & o;
        return s;
    endfunction

    function automatic slot_t tab_slot(input vec_t t);
        slot_t s;
        s.valid = 1'b1;
        s.a  = t.a;
        s.b  = t.b;
`ifdef BGD_MUL_SAT_EN
        s.e0 = t.d0s;
        s.e8 = t.d8s;
`else
        s.e0 = t.d0w;
        s.e8 = t.d8w;
`endif
        s.o0 = t.o0;
        s.o8 = t.o8;
        return s;
    endfunction

    task automatic check_outputs();
        chk("out_valid_a", int'(out_valid_a), int'(cur.valid));
        if (cur.valid) chk("dout_a", int'($signed(dout_a)), cur.e0);
        chk("ovf_a", int'(ovf_a), int'(cur.o0));
        chk("sticky_a", int'(sticky_a), int'(st_a));
        chk("out_valid_b", int'(out_valid_b), int'(cur.valid));
        if (cur.valid) chk("dout_b", int'($signed(dout_b)), cur.e8);
        chk("ovf_b", int'(ovf_b), int'(cur.o8));
        chk("sticky_b", int'(sticky_b), int'(st_b));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid_a"}, int'(out_valid_a), 0);
        chk({tag, "_dout_a"}, int'(dout_a), 0);
        chk({tag, "_ovf_a"}, int'(ovf_a), 0);
        chk({tag, "_sticky_a"}, int'(sticky_a), 0);
        chk({tag, "_out_valid_b"}, int'(out_valid_b), 0);
        chk({tag, "_dout_b"}, int'(dout_b), 0);
        chk({tag, "_ovf_b"}, int'(ovf_b), 0);
        chk({tag, "_sticky_b"}, int'(sticky_b), 0);
    endtask

    task automatic model_reset();
        hist.delete();
        cur  = mk_slot(1'b0, 0, 0);
        st_a = 1'b0;
        st_b = 1'b0;
    endtask

    // Driver: present one cycle of inputs, advance the model, clock, check.
    task automatic step(input bit c, input bit clr, input slot_t s);
        ce       = c;
        clr_ovf  = clr;
        in_valid = s.valid;
        din0     = 13'(s.a);
        din1     = 13'(s.b);
        if (c && cur.valid && cur.o0) st_a = 1'b1;
        else if (clr)                 st_a = 1'b0;
        if (c && cur.valid && cur.o8) st_b = 1'b1;
        else if (clr)                 st_b = 1'b0;
        if (c) begin
            hist.push_back(s);
            if (hist.size() == NS) cur = hist.pop_front();
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, mk_slot(1'b0, 0, 0));
    endtask

    function automatic int rnd_op();
        case ($urandom_range(5))
            0:       return -4096;
            1:       return 4095;
            default: return int'($urandom_range(8191)) - 4096;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int first_idx;
        int got[$];

        //           a      b     d0w    d0s  o0   d8w   d8s   o8
        tab[0]  = '{  100,   -3,  -300,  -300, 0,   -1,    -1, 0};
        tab[1]  = '{  100,  100,  1808,  4095, 1,   39,    39, 0};
        tab[2]  = '{ -100,  100, -1808, -4096, 1,  -39,   -39, 0};
        tab[3]  = '{  384, -256,     0, -4096, 1, -384,  -384, 0};
        tab[4]  = '{    3,   43,   129,   129, 0,    1,     1, 0};
        tab[5]  = '{    1,  127,   127,   127, 0,    0,     0, 0};
        tab[6]  = '{ 4095, 4095,     1,  4095, 1,  -32, 32767, 1};
        tab[7]  = '{-4096,-4096,     0,  4095, 1,    0, 32767, 1};
        tab[8]  = '{-4096,    1, -4096, -4096, 0,  -16,   -16, 0};
        tab[9]  = '{ 4095,    1,  4095,  4095, 0,   16,    16, 0};
        tab[10] = '{   64,   64, -4096,  4095, 1,   16,    16, 0};
        tab[11] = '{ -128,    1,  -128,  -128, 0,    0,     0, 0};
        tab[12] = '{ -129,    1,  -129,  -129, 0,   -1,    -1, 0};
        tab[13] = '{  128,    1,   128,   128, 0,    1,     1, 0};

        // Reset state
        reset = 1'b0; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; clr_ovf = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Single sample latency
        lat = -1;
        step(1'b1, 1'b0, mk_slot(1'b1, 100, -3));
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, mk_slot(1'b0, 0, 0));
            if (out_valid_a && lat < 0) lat = i;
        end
        chk("latency", lat, NS - 1);

        // Table vectors back to back
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, tab_slot(tab[i]));
        idle(6);

        // Sticky: set wins over clear, clear alone works while stalled
        step(1'b1, 1'b1, mk_slot(1'b0, 0, 0));
        step(1'b1, 1'b1, mk_slot(1'b0, 0, 0));
        step(1'b1, 1'b0, mk_slot(1'b1, 100, 100));
        idle(3);
        chk("ovf_exit", int'(ovf_a), 1);
        step(1'b1, 1'b1, mk_slot(1'b0, 0, 0));
        chk("sticky_set_wins", int'(sticky_a), 1);
        step(1'b0, 1'b1, mk_slot(1'b0, 0, 0));
        chk("sticky_clr_stalled", int'(sticky_a), 0);
        idle(4);

        // Stream of 8 with a 3-cycle stall after the third sample
        first_idx = -1;
        begin
            int k;
            k = 0;
            for (int i = 1; i <= 8; i++) begin
                if (i == 4) begin
                    for (int s = 0; s < 3; s++) begin
                        step(1'b0, 1'b0, mk_slot(1'b1, i, 2));
                        k++;
                    end
                end
                step(1'b1, 1'b0, mk_slot(1'b1, i, 2));
                k++;
                if (out_valid_a) begin
                    got.push_back(int'($signed(dout_a)));
                    if (first_idx < 0) first_idx = k;
                end
            end
            for (int i = 0; i < 6; i++) begin
                step(1'b1, 1'b0, mk_slot(1'b0, 0, 0));
                k++;
                if (out_valid_a) begin
                    got.push_back(int'($signed(dout_a)));
                    if (first_idx < 0) first_idx = k;
                end
            end
        end
        chk("stream_first_out_step", first_idx, NS + 3);
        chk("stream_count", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk("stream_value", got[i], 2 * (i + 1));
        end

        // Randomised traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(9) != 0), ($urandom_range(19) == 0),
                 mk_slot(bit'($urandom_range(1)), rnd_op(), rnd_op()));
        end
        idle(5);

        // Asynchronous reset mid-cycle with samples in flight
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, mk_slot(1'b1, 100, 100));
        chk("pre_reset_sticky", int'(sticky_a), 1);
        #3;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        #2;
        reset = 1'b1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bgd_mul_pipe_fx.md
Name: bgd_mul_pipe_fx

Overview:
- Parametrised, pipelined signed fixed-point multiplier for the BGD/sigmoid datapath IP cores.
- Successor of the fixed 13x13->13, 4-stage multiplier. Adds:
  - independent operand and result widths
  - configurable pipeline depth
  - valid tracking through the pipe
  - binary-point shift with rounding
  - overflow detection with a sticky flag
- Sits between the gradient/weight update logic and the activation stage. `ce` is driven by the top-level controller as a stall.

Parameters:
- A_WIDTH, 13, width of signed operand din0 (2..27)
- B_WIDTH, 13, width of signed operand din1 (2..18)
- P_WIDTH, 13, width of signed result dout (2..A_WIDTH+B_WIDTH)
- FRAC_SHIFT, 0, right shift applied to the full product (0..A_WIDTH+B_WIDTH-2)
- NUM_STAGE, 4, total latency in enabled cycles (3..8)

Ports:
- clk  in  1  clock, all flops rising-edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- ce  in  1  clock enable; 0 freezes the whole pipeline
- in_valid  in  1  din0/din1 carry a sample this cycle
- din0  in  A_WIDTH  signed operand A
- din1  in  B_WIDTH  signed operand B
- clr_ovf  in  1  synchronous clear of ovf_sticky; ignores ce
- out_valid  out  1  dout carries a result
- dout  out  P_WIDTH  signed result
- ovf  out  1  the result currently on dout did not fit in P_WIDTH
- ovf_sticky  out  1  latched OR of ovf since reset or the last clr_ovf

Behaviour:
- Reset
  - Asserted (reset=0): all pipeline registers, out_valid, dout, ovf and ovf_sticky go to 0 immediately, without waiting for a clock edge.
  - Samples in flight are discarded. No stale out_valid appears after release.
- Pipeline structure
  - Stage 1: register din0, din1, in_valid.
  - Stage 2: full product, A_WIDTH+B_WIDTH bits.
  - Stages 3..NUM_STAGE-1: pure delay registers.
  - Stage NUM_STAGE: round, shift, fit and register the result plus ovf.
- Latency and throughput
  - A sample accepted at enabled edge k appears on dout/out_valid after enabled edge k+NUM_STAGE-1, i.e. NUM_STAGE enabled cycles.
  - Throughput is 1 sample per enabled cycle.
- ce
  - ce=0: every pipeline register, including the valid chain, holds. Outputs stay stable.
  - No sample is dropped or duplicated across a stall.
- Invalid slots
  - in_valid=0 slots still propagate. Their dout value is don't-care.
  - The bench must only check dout when out_valid=1.
  - ovf is forced to 0 when out_valid=0.
- Arithmetic
  - Full product prod = signed(din0)*signed(din1), computed exactly.
  - FRAC_SHIFT>0: r = (prod + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up, arithmetic shift). Compute on A_WIDTH+B_WIDTH+1 bits so the rounding add never wraps.
  - FRAC_SHIFT=0: r = prod.
  - Fit: ovf = 1 when r is outside [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
  - When r fits, dout = r.
  - Out-of-range handling is set by BGD_MUL_SAT_EN (see Optional Feature).
- ovf_sticky
  - Set on any cycle where out_valid=1, ovf=1 and ce=1.
  - clr_ovf=1 clears it, except when a set condition occurs in the same cycle: set wins and ovf_sticky stays 1.
- Legacy compatibility
  - With default parameters and the macro undefined, dout values and latency equal the legacy 13x13->13 4-stage multiplier.

Optional Feature:
- Macro: BGD_MUL_SAT_EN
- Defined: out-of-range r saturates.
  - Positive overflow gives 2^(P_WIDTH-1)-1.
  - Negative overflow gives -2^(P_WIDTH-1).
  - Adds one compare/mux in the final stage; latency is unchanged.
- Undefined: dout = r[P_WIDTH-1:0] (two's-complement wrap).
- ovf and ovf_sticky behave identically in both builds.

Test Plan:
1. Defaults, ce=1: din0=100, din1=-3, in_valid=1 for one cycle -> after 4 cycles out_valid=1, dout=-300 (13'h1ED4), ovf=0; out_valid=0 on the following cycle.
2. Defaults: din0=100, din1=100 (prod 10000) -> ovf=1, ovf_sticky=1.
   - Macro undefined: dout=1808.
   - BGD_MUL_SAT_EN defined: dout=4095.
   - din0=-100, din1=100 with SAT: dout=-4096.
3. FRAC_SHIFT=8, P_WIDTH=16, macro undefined:
   - (384,-256) -> -384
   - (3,43) -> 1 (129 rounds up)
   - (1,127) -> 0
   - ovf=0 throughout.
4. Stream of 8 back-to-back samples (din0=i, din1=2, i=1..8) with ce=0 for 3 cycles after the 3rd sample -> dout sequence 2,4,..,16 in order, none lost or repeated. Outputs are frozen during the stall. Total latency = 4 + 3 stall cycles.
5. Reset=0 asserted mid-clock with 3 valid samples in flight -> out_valid, dout, ovf, ovf_sticky go to 0 before the next edge. After reset=1, out_valid stays 0 until new input.
6. clr_ovf=1 in the same cycle an overflowing result exits with ce=1 -> ovf_sticky remains 1. clr_ovf=1 alone on the next cycle -> ovf_sticky=0, including while ce=0.
